cla_pipe_adder: RTL



---
 rtl/cla_pipe_adder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
// Ports: clk, rst_n; in_valid/in_ready, a, b, cin, sub; out_valid/out_ready, sum, cout, ovf, zero.
module cla_pipe_adder #(
   parameter int adder_size   = 32,
   parameter int data_width   = 4,
   parameter int stage_blocks = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [adder_size-1:0] a,
   input  logic [adder_size-1:0] b,
   input  logic                  cin,
   input  logic                  sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [adder_size-1:0] sum,
   output logic                  cout,
   output logic                  ovf,
   output logic                  zero
);

   localparam int W  = adder_size;
   localparam int DW = data_width;
   localparam int SB = stage_blocks;
   localparam int SW = DW * SB;
   localparam int NB = W / DW;
   localparam int NS = NB / SB;

   generate
      if ((adder_size % (data_width * stage_blocks)) != 0) begin : g_bad_cfg
         $error("cla_pipe_adder: adder_size must be a multiple of data_width*stage_blocks");
      end
   endgenerate

   // Per-bit lookahead carries of one block: c[i+1] is the full
   // sum-of-products over g/p of bits i..0 and the block carry-in.
   function automatic logic [DW:0] blk_carry(
      input logic [DW-1:0] g,
      input logic [DW-1:0] p,
      input logic          ci
   );
      logic [DW:0] c;
      logic        t;
      logic        pp;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < DW; i++) begin
         t  = g[i];
         pp = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            t  = t | (pp & g[j]);
            pp = pp & p[j];
         end
         c[i+1] = t | (pp & ci);
      end
      return c;
   endfunction

   logic [W-1:0] a_q [NS];
   logic [W-1:0] b_q [NS];
   logic [W-1:0] s_q [NS];
   logic [W-1:0] s_d [NS];
   logic [NS-1:0] v_q;
   logic [NS-1:0] c_q;
   logic [NS-1:0] c_d;
   logic          cm_q;
   logic          cm_d;

   logic [W-1:0] ai [NS];
   logic [W-1:0] bi [NS];
   logic [W-1:0] si [NS];
   logic [NS-1:0] ci;
   logic [NS-1:0] vi;

   logic         advance;
   logic [W-1:0] b_eff;
   logic         c0;

   assign advance = !v_q[NS-1] || out_ready;
   assign b_eff   = sub ? ~b : b;
   assign c0      = sub ? 1'b1 : cin;

   always_comb begin
      ai[0] = a;
      bi[0] = b_eff;
      si[0] = '0;
      ci[0] = c0;
      vi[0] = in_valid;
      for (int k = 1; k < NS; k++) begin
         ai[k] = a_q[k-1];
         bi[k] = b_q[k-1];
         si[k] = s_q[k-1];
         ci[k] = c_q[k-1];
         vi[k] = v_q[k-1];
      end
   end

   always_comb begin
      logic [DW-1:0] g;
      logic [DW-1:0] p;
      logic [DW:0]   cv;
      logic          cc;
      int            lo;
      g    = '0;
      p    = '0;
      cv   = '0;
      cc   = 1'b0;
      lo   = 0;
      cm_d = 1'b0;
      c_d  = '0;
      for (int k = 0; k < NS; k++) begin
         s_d[k] = si[k];
         cc     = ci[k];
         for (int blk = 0; blk < SB; blk++) begin
            lo = k * SW + blk * DW;
            g  = ai[k][lo +: DW] & bi[k][lo +: DW];
            p  = ai[k][lo +: DW] ^ bi[k][lo +: DW];
            cv = blk_carry(g, p, cc);
            s_d[k][lo +: DW] = p ^ cv[DW-1:0];
            // carry into the MSB feeds the signed overflow flag
            if (k == NS - 1 && blk == SB - 1) begin
               cm_d = cv[DW-1];
            end
            cc = cv[DW];
         end
         c_d[k] = cc;
      end
   end

   // Data registers load only with a valid op, so X operands on
   // bubbles never reach the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q  <= '0;
         c_q  <= '0;
         cm_q <= 1'b0;
         for (int k = 0; k < NS; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else if (advance) begin
         for (int k = 0; k < NS; k++) begin
            v_q[k] <= vi[k];
            if (vi[k]) begin
               a_q[k] <= ai[k];
               b_q[k] <= bi[k];
               s_q[k] <= s_d[k];
               c_q[k] <= c_d[k];
            end
         end
         if (vi[NS-1]) begin
            cm_q <= cm_d;
         end
      end
   end

   // Skew-register bits below the current slice are never read again.
   logic unused_skew;
   always_comb begin
      unused_skew = 1'b0;
      for (int k = 0; k < NS; k++) begin
         unused_skew = unused_skew ^ (^a_q[k]) ^ (^b_q[k]);
      end
   end

   assign in_ready  = advance;
   assign out_valid = v_q[NS-1];
   assign sum       = s_q[NS-1];
   assign cout      = c_q[NS-1];
   assign ovf       = cm_q ^ c_q[NS-1];
   // qualified by valid so the flag reads 0 while the output is empty
   assign zero      = v_q[NS-1] & ~|s_q[NS-1];

endmodule
